// File: rtl/alu_pkg.sv
// Shared definitions for the ALU core: op codes, status bit positions and FSM encoding.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_NOTB = 3'b011,
    OP_MUL  = 3'b100
  } op_e;

  localparam int unsigned STAT_Z = 0;
  localparam int unsigned STAT_N = 1;
  localparam int unsigned STAT_V = 2;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE     = 1'b0;
  localparam state_t ST_MUL_BUSY = 1'b1;

  function automatic logic [2:0] pack_status(input logic v, input logic n, input logic z);
    logic [2:0] s;
    s         = '0;
    s[STAT_V] = v;
    s[STAT_N] = n;
    s[STAT_Z] = z;
    return s;
  endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add unsigned multiplier: one multiplier bit per cycle after a latch cycle.
module mul_iter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] prod_o
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] acc_q, acc_d, pp;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;
  logic               last;

  always_comb begin
    pp = '0;
    if (b_q[cnt_q]) pp = {{WIDTH{1'b0}}, a_q} << cnt_q;
    acc_d = acc_q + pp;
  end

  assign last = busy_q && (cnt_q == LAST);
  // The final sum is exposed combinationally so the core can load it on the last iteration edge.
  assign done_o = last;
  assign prod_o = acc_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      a_q    <= a_i;
      b_q    <= b_i;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc_q <= acc_d;
      if (last) busy_q <= 1'b0;
      else      cnt_q  <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/alu_core.sv
// Registered, handshaked ALU: single-cycle ADD/SUB/AND/NOTB plus an iterative MUL.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] computedValue,
  output logic [2:0]       status
);

  state_t             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [2:0]         status_q, status_d;

  logic               accept, is_mul, is_sub;
  logic               load_sc, load_mul, mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   b_eff, sc_res;
  logic [WIDTH:0]     sum_ext;
  logic               add_ovf, sc_v;
  op_e                op_sel;

  assign op_sel   = op_e'(op);
  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (op_sel == OP_MUL);
  assign is_sub   = (op_sel == OP_SUB);

  // One adder serves both ADD and SUB (A + ~B + 1).
  assign b_eff   = is_sub ? ~Bin : Bin;
  assign sum_ext = {1'b0, Ain} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
  assign add_ovf = (Ain[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum_ext[WIDTH-1]) ^ sum_ext[WIDTH];

  always_comb begin
    sc_res = '0;
    sc_v   = 1'b0;
    case (op_sel)
      OP_ADD, OP_SUB: begin
        sc_res = sum_ext[WIDTH-1:0];
        sc_v   = add_ovf;
      end
      OP_AND:  sc_res = Ain & Bin;
      OP_NOTB: sc_res = ~Bin;
      default: sc_res = '0;
    endcase
  end

  mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (reset),
    .start_i (accept && is_mul),
    .a_i     (Ain),
    .b_i     (Bin),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  assign load_sc  = accept && !is_mul;
  assign load_mul = (state_q == ST_MUL_BUSY) && mul_done;

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    status_d    = status_q;
    out_valid_d = out_valid_q;
    if (out_ready) out_valid_d = 1'b0;
    if (load_sc) begin
      result_d    = sc_res;
      status_d    = pack_status(sc_v, sc_res[WIDTH-1], sc_res == '0);
      out_valid_d = 1'b1;
    end
    if (accept && is_mul) state_d = ST_MUL_BUSY;
    if (load_mul) begin
      result_d    = mul_prod[WIDTH-1:0];
      status_d    = pack_status(|mul_prod[2*WIDTH-1:WIDTH], mul_prod[WIDTH-1],
                                mul_prod[WIDTH-1:0] == '0);
      out_valid_d = 1'b1;
      state_d     = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      status_q    <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      status_q    <= status_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign computedValue = result_q;
  assign status        = status_q;

endmodule

// File: tb/tb_alu_core.sv
// Directed scoreboard bench for alu_core at WIDTH=16.
module tb_alu_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [15:0] Ain, Bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] computedValue;
  logic [2:0]  status;

  logic [18:0] sb_q[$];
  int          ncmp = 0;
  int          nfail = 0;

  alu_core #(.WIDTH(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .op            (op),
    .Ain           (Ain),
    .Bin           (Bin),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .computedValue (computedValue),
    .status        (status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop();
    logic [18:0] e;
    if (sb_q.size() == 0) begin
      chk("sb unexpected result", {13'd0, status, computedValue}, 32'hFFFF_FFFF);
    end else begin
      e = sb_q.pop_front();
      chk("sb result", {13'd0, status, computedValue}, {13'd0, e});
    end
  endtask

  // Inputs are driven just after a falling edge; a result is consumed when it is handshaken.
  task automatic cyc();
    #1;
    if (out_valid && out_ready) sb_pop();
    @(negedge clk);
  endtask

  task automatic send(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] er, input logic [2:0] es, input bit push);
    in_valid = 1'b1;
    op       = o;
    Ain      = a;
    Bin      = b;
    if (push) sb_q.push_back({es, er});
  endtask

  task automatic issue_and_wait(input string tag, input int exp_lat);
    int lat;
    cyc();
    in_valid = 1'b0;
    Ain      = 16'hDEAD;
    Bin      = 16'hBEEF;
    op       = 3'b010;
    lat      = 1;
    while (!out_valid && lat < 40) begin
      chk({tag, " in_ready busy"}, {31'd0, in_ready}, 32'd0);
      cyc();
      lat++;
    end
    chk({tag, " latency"}, lat, exp_lat);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; op = '0; Ain = '0; Bin = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset value", {16'd0, computedValue}, 32'd0);
    chk("reset status", {29'd0, status}, 32'd0);
    reset = 1'b0;
    #1;
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    send(3'b000, 16'h7FFF, 16'h0001, 16'h8000, 3'b110, 1);
    issue_and_wait("add ovf", 1);
    cyc();

    send(3'b001, 16'h0005, 16'h0005, 16'h0000, 3'b001, 1);
    cyc();
    send(3'b010, 16'hF0F0, 16'h0FF0, 16'h00F0, 3'b000, 1);
    chk("b2b in_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    in_valid = 1'b0;
    chk("b2b and valid", {31'd0, out_valid}, 32'd1);
    chk("b2b and value", {16'd0, computedValue}, 32'h00F0);
    cyc();

    send(3'b011, 16'h1234, 16'h0000, 16'hFFFF, 3'b010, 1);
    issue_and_wait("notb", 1);
    send(3'b111, 16'h1234, 16'h5678, 16'h0000, 3'b001, 1);
    issue_and_wait("reserved", 1);
    cyc();

    send(3'b100, 16'h0100, 16'h0100, 16'h0000, 3'b101, 1);
    issue_and_wait("mul ovf", 17);
    cyc();
    send(3'b100, 16'h0003, 16'h0007, 16'h0015, 3'b000, 1);
    issue_and_wait("mul small", 17);
    cyc();

    out_ready = 1'b0;
    send(3'b000, 16'h1234, 16'h1111, 16'h2345, 3'b000, 1);
    issue_and_wait("bp add", 1);
    send(3'b001, 16'h0009, 16'h0002, 16'h0007, 3'b000, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp value", {16'd0, computedValue}, 32'h2345);
      chk("bp status", {29'd0, status}, 32'd0);
      chk("bp in_ready", {31'd0, in_ready}, 32'd0);
      cyc();
    end
    out_ready = 1'b1;
    #1;
    chk("bp release in_ready", {31'd0, in_ready}, 32'd1);
    issue_and_wait("bp sub", 1);
    chk("bp sub value", {16'd0, computedValue}, 32'h0007);

    send(3'b100, 16'h1234, 16'h5678, 16'h0000, 3'b000, 0);
    cyc();
    in_valid = 1'b0;
    repeat (5) cyc();
    reset = 1'b1;
    #1;
    chk("abort out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort value", {16'd0, computedValue}, 32'd0);
    chk("abort status", {29'd0, status}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post-reset in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    send(3'b000, 16'h0002, 16'h0003, 16'h0005, 3'b000, 1);
    issue_and_wait("post-reset add", 1);
    chk("post-reset value", {16'd0, computedValue}, 32'h0005);
    cyc();
    repeat (3) cyc();
    chk("no stray output", {31'd0, out_valid}, 32'd0);
    chk("sb drained", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
